// File: rtl/icache_axi4_refill.sv
// AXI4 read-only line refill engine for the ICache: split mode (single-beat ARs,
// bounded outstanding) for XIP-style slaves, burst mode (one INCR AR) for SDRAM/PSRAM.
//   state | meaning
//   IDLE  | waiting for a refill request
//   ISSUE | ARs remain to be sent
//   DRAIN | all ARs accepted, collecting R beats
module icache_axi4_refill #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_len,
  input  logic              req_burst,
  input  logic              flush,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_last,
  output logic              resp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  output logic [ID_W-1:0]   m_axi_arid,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arlock,
  output logic [3:0]        m_axi_arcache,
  output logic [2:0]        m_axi_arprot,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  input  logic              m_axi_rlast,
  input  logic [ID_W-1:0]   m_axi_rid
);

  localparam int BYTES = DATA_W / 8;
  localparam int SZ    = $clog2(BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [8:0]          total_q, total_d, issued_q, issued_d, recv_q, recv_d;
  logic [7:0]          len_q, len_d;
  logic                mode_q, mode_d, discard_q, discard_d, err_q, err_d;
  logic                resp_valid_d, resp_last_d, resp_err_d;
  logic [DATA_W-1:0]   resp_data_d;
  logic [8:0]          outst;
  logic                ar_hs, r_hs, last_beat, beat_err, discard_now;

  assign busy          = (state_q != IDLE);
  assign req_ready     = (state_q == IDLE) && !flush;
  assign m_axi_rready  = busy;
  assign outst         = issued_q - recv_q;
  // Depends only on registered counters, so once high it holds until accepted.
  assign m_axi_arvalid = (state_q == ISSUE) && (issued_q < total_q) && (outst < 9'(MAX_OUTST));
  assign m_axi_araddr  = base_q + (ADDR_W'(issued_q) << SZ);
  assign m_axi_arlen   = mode_q ? len_q : 8'd0;
  assign m_axi_arid    = '0;
  assign m_axi_arsize  = 3'(SZ);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;

  assign ar_hs       = m_axi_arvalid && m_axi_arready;
  assign r_hs        = m_axi_rvalid && m_axi_rready;
  assign discard_now = discard_q || (flush && busy);
  assign last_beat   = r_hs && (recv_q + 9'd1 == total_q);
  // Non-OKAY response, foreign ID, or a burst rlast before the counted last beat.
  assign beat_err    = (m_axi_rresp != 2'b00) || (m_axi_rid != '0) ||
                       (mode_q && m_axi_rlast && !last_beat);

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    total_d      = total_q;
    issued_d     = issued_q;
    recv_d       = recv_q;
    len_d        = len_q;
    mode_d       = mode_q;
    discard_d    = discard_q;
    err_d        = err_q;
    resp_valid_d = 1'b0;
    resp_last_d  = 1'b0;
    resp_err_d   = 1'b0;
    resp_data_d  = resp_data;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          base_d    = req_addr & ALIGN_MASK;
          total_d   = {1'b0, req_len} + 9'd1;
          len_d     = req_len;
          mode_d    = req_burst;
          issued_d  = '0;
          recv_d    = '0;
          discard_d = 1'b0;
          err_d     = 1'b0;
          state_d   = ISSUE;
        end
      end
      default: begin
        if (flush) begin
          discard_d = 1'b1;
          // A burst AR already covers the whole line; only split mode shrinks.
          if (state_q == ISSUE && !mode_q) total_d = issued_q + 9'(m_axi_arvalid);
        end
        if (ar_hs) issued_d = mode_q ? total_q : issued_q + 9'd1;
        if (r_hs) begin
          recv_d = recv_q + 9'd1;
          if (!discard_now) begin
            resp_valid_d = 1'b1;
            resp_data_d  = m_axi_rdata;
          end
          if (beat_err) err_d = 1'b1;
        end
        if (state_q == ISSUE) begin
          if (issued_d == total_d) state_d = DRAIN;
        end else if (last_beat) begin
          state_d     = IDLE;
          resp_last_d = !discard_now;
          resp_err_d  = !discard_now && (err_q || beat_err);
        end else if (recv_q == total_q) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      total_q    <= '0;
      issued_q   <= '0;
      recv_q     <= '0;
      len_q      <= '0;
      mode_q     <= 1'b0;
      discard_q  <= 1'b0;
      err_q      <= 1'b0;
      resp_valid <= 1'b0;
      resp_last  <= 1'b0;
      resp_err   <= 1'b0;
      resp_data  <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      total_q    <= total_d;
      issued_q   <= issued_d;
      recv_q     <= recv_d;
      len_q      <= len_d;
      mode_q     <= mode_d;
      discard_q  <= discard_d;
      err_q      <= err_d;
      resp_valid <= resp_valid_d;
      resp_last  <= resp_last_d;
      resp_err   <= resp_err_d;
      resp_data  <= resp_data_d;
    end
  end

endmodule

// File: tb/tb_icache_axi4_refill.sv
// Scoreboard bench for icache_axi4_refill: behavioural AXI read slave plus an
// expected-beat queue filled at request time and drained on resp_valid.
module tb_icache_axi4_refill;
  localparam int AW = 32, DW = 32, IW = 4, MO = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          req_valid, req_ready, req_burst, flush;
  logic [AW-1:0] req_addr;
  logic [7:0]    req_len;
  logic          resp_valid, resp_last, resp_err, busy;
  logic [DW-1:0] resp_data;
  logic [AW-1:0] m_axi_araddr;
  logic          m_axi_arvalid, m_axi_arready, m_axi_arlock;
  logic [IW-1:0] m_axi_arid, m_axi_rid;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize, m_axi_arprot;
  logic [1:0]    m_axi_arburst, m_axi_rresp;
  logic [3:0]    m_axi_arcache;
  logic [DW-1:0] m_axi_rdata;
  logic          m_axi_rvalid, m_axi_rready, m_axi_rlast;

  icache_axi4_refill #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .MAX_OUTST(MO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_len(req_len), .req_burst(req_burst), .flush(flush),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_last(resp_last),
    .resp_err(resp_err), .busy(busy),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_arid(m_axi_arid), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache),
    .m_axi_arprot(m_axi_arprot),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready), .m_axi_rlast(m_axi_rlast), .m_axi_rid(m_axi_rid)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {logic [31:0] data; logic last; logic err;} exp_t;
  typedef struct {logic [31:0] addr; int t; int idx; logic last;} beat_t;
  exp_t  exp_q[$];
  beat_t beats[$];

  int cyc = 0, ar_cnt = 0, r_cnt = 0, beat_seq = 0, max_out = 0;
  int hold_until = 0, inj_resp_idx = -1, inj_rlast_idx = -1, ar_block_at = 1000;
  int lat = 2;
  logic [7:0] exp_arlen = 8'd0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  assign m_axi_arready = (ar_cnt < ar_block_at);
  assign m_axi_rid     = '0;

  // AXI read slave: every accepted AR expands into beats, returned in order after lat cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axi_rvalid <= 1'b0;
      m_axi_rdata  <= '0;
      m_axi_rresp  <= 2'b00;
      m_axi_rlast  <= 1'b0;
      beats.delete();
    end else begin
      cyc++;
      if (m_axi_arvalid && m_axi_arready) begin
        ar_cnt++;
        check("arlen", m_axi_arlen, exp_arlen);
        for (int i = 0; i <= int'(m_axi_arlen); i++) begin
          beats.push_back('{addr: m_axi_araddr + 32'(i * 4), t: cyc + lat, idx: beat_seq,
                            last: (i == int'(m_axi_arlen))});
          beat_seq++;
        end
      end
      if (m_axi_rvalid && m_axi_rready) begin
        beats.delete(0);
        r_cnt++;
      end
      if (ar_cnt - r_cnt > max_out) max_out = ar_cnt - r_cnt;
      if (beats.size() > 0 && cyc >= beats[0].t && cyc >= hold_until) begin
        m_axi_rvalid <= 1'b1;
        m_axi_rdata  <= mem(beats[0].addr);
        m_axi_rresp  <= (beats[0].idx == inj_resp_idx) ? 2'b10 : 2'b00;
        m_axi_rlast  <= beats[0].last || (beats[0].idx == inj_rlast_idx);
      end else begin
        m_axi_rvalid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && resp_valid) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("resp_data", resp_data, e.data);
        check("resp_last", resp_last, e.last);
        if (e.last) check("resp_err", resp_err, e.err);
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [7:0] len, input logic burst, input logic err);
    for (int i = 0; i <= int'(len); i++)
      exp_q.push_back('{data: mem((a & ~32'h3) + 32'(i * 4)), last: (i == int'(len)), err: err});
    exp_arlen = burst ? len : 8'd0;
    beat_seq  = 0;
    req_addr  = a;
    req_len   = len;
    req_burst = burst;
    req_valid = 1'b1;
    check("req_ready_idle", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, (!busy && exp_q.size() == 0), 1'b1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  int a0, r0, n, rem;
  logic [31:0] pend_addr;

  initial begin
    req_valid = 1'b0; req_addr = '0; req_len = '0; req_burst = 1'b0; flush = 1'b0;
    #12;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_arvalid", m_axi_arvalid, 1'b0);
    check("rst_rready", m_axi_rready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_resp", {resp_valid, resp_last, resp_err}, 3'b000);
    check("rst_araddr", m_axi_araddr, 32'h0);
    check("rst_resp_data", resp_data, 32'h0);
    check("ar_static", {m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arid},
          {3'd2, 2'b01, 1'b0, 4'b0011, 3'b000, 4'h0});
    @(posedge clk); #1 rst = 1'b0;

    // split, len 3
    a0 = ar_cnt;
    send(32'h3000_0000, 8'd3, 1'b0, 1'b0);
    wait_done("t1_done");
    check("t1_ar_count", ar_cnt - a0, 4);

    // split, len 7, slave withholds rvalid for 5 cycles
    max_out = 0;
    hold_until = cyc + 5;
    send(32'h3000_0100, 8'd7, 1'b0, 1'b0);
    wait_done("t2_done");
    check("t2_max_outst", max_out, MO);

    // burst, len 3
    a0 = ar_cnt;
    send(32'hA000_0040, 8'd3, 1'b1, 1'b0);
    wait_done("t3_done");
    check("t3_ar_count", ar_cnt - a0, 1);

    // burst with early rlast on beat 2
    inj_rlast_idx = 1;
    send(32'hA000_0080, 8'd3, 1'b1, 1'b1);
    wait_done("t3b_done");
    inj_rlast_idx = -1;

    // SLVERR on beat 2, then a clean refill
    inj_resp_idx = 1;
    send(32'h3000_0202, 8'd3, 1'b0, 1'b1);
    wait_done("t4_done");
    inj_resp_idx = -1;
    send(32'h3000_0300, 8'd3, 1'b0, 1'b0);
    wait_done("t4b_done");

    // flush after the 3rd AR handshake with the 4th AR pending
    a0 = ar_cnt; r0 = r_cnt;
    ar_block_at = a0 + 3;
    send(32'h3000_0400, 8'd7, 1'b0, 1'b0);
    n = 0;
    while (!(ar_cnt == a0 + 3 && m_axi_arvalid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("t5_4th_ar_pending", (ar_cnt == a0 + 3 && m_axi_arvalid), 1'b1);
    flush = 1'b1;
    pend_addr = m_axi_araddr;
    rem = (r_cnt - r0) - (8 - exp_q.size());
    while (exp_q.size() > rem && exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
    @(posedge clk); #1;
    flush = 1'b0;
    check("t5_arvalid_held", m_axi_arvalid, 1'b1);
    check("t5_araddr_held", m_axi_araddr, pend_addr);
    repeat (3) @(posedge clk);
    #1 ar_block_at = 1000;
    wait_done("t5_done");
    check("t5_ar_count", ar_cnt - a0, 4);
    check("t5_r_count", r_cnt - r0, 4);
    check("t5_req_ready", req_ready, 1'b1);

    // flush in IDLE blocks acceptance
    a0 = ar_cnt;
    flush = 1'b1; req_valid = 1'b1; req_addr = 32'h3000_0500; req_len = 8'd1; req_burst = 1'b0;
    #1 check("t6_req_ready", req_ready, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t6_no_ar", ar_cnt - a0, 0);
    check("t6_busy", busy, 1'b0);

    // async reset while draining a burst
    a0 = ar_cnt;
    hold_until = cyc + 100;
    send(32'hA000_0100, 8'd3, 1'b1, 1'b0);
    n = 0;
    while (ar_cnt == a0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("t7_in_drain", {busy, m_axi_rready, m_axi_arvalid}, 3'b110);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t7_rst_arvalid", m_axi_arvalid, 1'b0);
    check("t7_rst_rready", m_axi_rready, 1'b0);
    check("t7_rst_busy", busy, 1'b0);
    exp_q.delete();
    hold_until = 0;
    @(posedge clk); #1 rst = 1'b0;
    check("t7_req_ready", req_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/icache_axi4_refill.md
# icache_axi4_refill

Parametrised AXI4 read-only refill engine between the ICache and the SoC crossbar. It fetches a cache line of N beats in one of two modes, selected per request. Split mode issues N single-beat ARs with up to MAX_OUTST outstanding, for Flash XIP and other non-burst slaves. Burst mode issues one native INCR AR of N beats, for SDRAM/PSRAM. Also provides flush-with-cancel, error reporting and a valid/ready request handshake.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; 32 or 64
- ID_W, 4, AXI ID width; arid is driven to constant 0
- MAX_OUTST, 4, maximum outstanding single-beat ARs in split mode; power of two, 1..8

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  1  refill request
- req_ready  out  1  request accepted when req_valid && req_ready
- req_addr  in  ADDR_W  line base address; low log2(DATA_W/8) bits are ignored (forced 0)
- req_len  in  8  beats minus 1
- req_burst  in  1  1 = native burst mode, 0 = split mode
- flush  in  1  abandon current refill
- resp_valid  out  1  one-cycle data pulse
- resp_data  out  DATA_W  beat data
- resp_last  out  1  final beat of a non-discarded refill
- resp_err  out  1  sticky-per-refill error; valid only with resp_last
- busy  out  1  state != IDLE
- m_axi_araddr / arvalid / arready / arid / arlen / arsize / arburst / arlock / arcache / arprot  AXI AR channel
  - arsize = log2(DATA_W/8)
  - arburst = 01
  - arlock = 0
  - arcache = 0011
  - arprot = 000
- m_axi_rdata / rresp / rvalid / rready / rlast / rid  AXI R channel

## Operation
- There are no write channels; the top level ties them off.
- States:
  - IDLE
  - ISSUE: ARs remain to be sent
  - DRAIN: all ARs accepted, awaiting R beats
- `req_ready = (state == IDLE) && !flush`.
- On request acceptance, latch:
  - base = aligned req_addr
  - total = req_len + 1 (9-bit)
  - mode = req_burst
  - clear issued, recv, discard, err
  - go to ISSUE.
- Burst mode:
  - A single AR with araddr = base and arlen = req_len.
  - On handshake, issued = total; go to DRAIN.
- Split mode:
  - araddr = base + issued*(DATA_W/8), with arlen = 0.
  - arvalid is asserted while issued < total && (issued − recv) < MAX_OUTST.
  - issued increments on each handshake.
  - Go to DRAIN when issued reaches total.
- rready = 1 whenever busy; the ICache never stalls.
- Each R handshake:
  - recv++ (9-bit).
  - If !discard: resp_valid = 1 and resp_data = rdata, registered.
  - If rresp != 00, set err.
- Completion: in DRAIN with recv + 1 == total on an R handshake:
  - resp_last = !discard
  - resp_err = err | (rresp != 00)
  - go to IDLE.
- Completion is counted by beats. rlast is not used for completion. In burst mode, rlast arriving on any beat other than the counted last beat sets err.
- Flush while busy:
  - discard = 1.
  - total is clamped to issued, or to issued + 1 if arvalid is currently high and not yet accepted. That AR must still complete its handshake, per AXI rules.
  - No further ARs are issued.
  - In-flight beats are drained silently. If recv == total, the engine returns to IDLE on the next cycle.
- flush in IDLE: no effect, and blocks acceptance that cycle.
- AR handshake and R handshake in the same cycle: both counters update. The outstanding check uses the pre-update values.

## Timing
- Reset values:
  - state IDLE
  - all counters 0
  - arvalid, rready, resp_valid, resp_last, resp_err, busy = 0
  - araddr and resp_data = 0
  - req_ready = 1
- Request accepted at cycle T: arvalid = 1 at T+1.
- R handshake at cycle T: resp_valid is asserted at T+1. resp_last / resp_err are asserted at T+1 on the final beat. busy = 0 from T+1.
- Split-mode back-to-back: the next AR may be presented the cycle after a handshake. Throughput is 1 beat/cycle if the slave allows it.
- arvalid, once high, holds with stable araddr until arready, including through flush and reset-free operation.
- Async reset mid-transaction: all outputs return to their reset values immediately. The bus is assumed reset together with the engine.

## Test plan
- Split mode, base 0x3000_0000, len 3, slave with 2-cycle latency and MAX_OUTST = 4 → ARs to 0x…00, 04, 08, 0C, all arlen = 0. Four resp_valid pulses with matching data; resp_last only on the 4th; resp_err = 0.
- Split mode, len 7, MAX_OUTST = 2, slave holds rvalid low for 5 cycles → never more than 2 unanswered ARs; 8 beats delivered in address order.
- Burst mode, base 0xA000_0040, len 3 → exactly one AR with arlen = 3. Four beats delivered; resp_last on beat 4. A second test injects early rlast on beat 2 → resp_err = 1 on beat 4.
- Split mode, len 7, flush asserted after the 3rd AR handshake while the 4th arvalid is pending → the 4th AR still handshakes, no 5th AR is issued, zero resp_valid pulses after the flush, busy drops after the 4th R beat, and req_ready returns to 1.
- Beat 2 returns rresp = 10 → resp_err = 1 with resp_last; the next refill reports resp_err = 0.
- Request with flush high in IDLE → req_ready = 0 and no AR. Async rst asserted during DRAIN → arvalid, rready and busy go to 0 within the same cycle.
